// File: rtl/pc_flag_ctrl_pkg.sv
// Shared constants for the PC/flag controller: opcodes, branch conditions,
// flag bit positions and the controller FSM state type.
package pc_flag_ctrl_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_XOR = 4'd2;
  localparam logic [3:0] OP_RED = 4'd3;
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRA = 4'd5;
  localparam logic [3:0] OP_ROR = 4'd6;
  localparam logic [3:0] OP_B   = 4'd12;
  localparam logic [3:0] OP_BR  = 4'd13;
  localparam logic [3:0] OP_PCS = 4'd14;
  localparam logic [3:0] OP_HLT = 4'd15;

  localparam logic [2:0] CC_NE   = 3'd0;
  localparam logic [2:0] CC_EQ   = 3'd1;
  localparam logic [2:0] CC_GT   = 3'd2;
  localparam logic [2:0] CC_LT   = 3'd3;
  localparam logic [2:0] CC_GE   = 3'd4;
  localparam logic [2:0] CC_LE   = 3'd5;
  localparam logic [2:0] CC_OVFL = 3'd6;
  localparam logic [2:0] CC_UNC  = 3'd7;

  localparam int FLAG_N = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

endpackage

// File: rtl/pc_flag_ctrl_branch_cond_eval.sv
// Combinational branch condition evaluator over the {N,V,Z} flag register.
module branch_cond_eval
  import pc_flag_ctrl_pkg::*;
(
  input  logic [2:0] cond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic n, v, z;

  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];
  assign z = flags[FLAG_Z];

  always_comb begin
    taken = 1'b0;
    unique case (cond)
      CC_NE:   taken = ~z;
      CC_EQ:   taken = z;
      CC_GT:   taken = ~z & ~n;
      CC_LT:   taken = n;
      CC_GE:   taken = z | (~z & ~n);
      CC_LE:   taken = n | z;
      CC_OVFL: taken = v;
      CC_UNC:  taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_flag_ctrl.sv
// Program counter and architectural {N,V,Z} flag owner with RUN/HALT control.
// Optional taken-branch counter enabled by `define PC_FLAG_CTRL_PERF_CNT_EN.
module pc_flag_ctrl
  import pc_flag_ctrl_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int          PC_STEP  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_valid,
  input  logic        stall,
  input  logic [3:0]  opcode,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] br_target,
  input  logic [2:0]  alu_flag,
  output logic [15:0] pc,
  output logic [2:0]  flags,
  output logic        branch_taken,
`ifdef PC_FLAG_CTRL_PERF_CNT_EN
  output logic [15:0] taken_cnt,
`endif
  output logic        halted
);

  localparam logic [15:0] STEP = 16'(PC_STEP);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic        branch_taken_q, branch_taken_d;

  logic        retire;
  logic        cond_taken;
  logic        br_taken;
  logic [15:0] pc2;
  logic [15:0] b_offset;

  // Condition uses the flags as they stood before this instruction writes them.
  branch_cond_eval u_cond (
    .cond  (cond),
    .flags (flags_q),
    .taken (cond_taken)
  );

  assign retire   = instr_valid & ~stall & (state_q == ST_RUN);
  assign pc2      = pc_q + STEP;
  assign b_offset = {{6{imm9[8]}}, imm9, 1'b0};
  assign br_taken = retire & cond_taken & ((opcode == OP_B) | (opcode == OP_BR));

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    flags_d        = flags_q;
    branch_taken_d = 1'b0;

    if (retire) begin
      unique case (opcode)
        OP_ADD, OP_SUB: flags_d = alu_flag;
        OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR:
          flags_d[FLAG_Z] = alu_flag[FLAG_Z];
        default: flags_d = flags_q;
      endcase

      unique case (opcode)
        OP_B:    pc_d = cond_taken ? (pc2 + b_offset) : pc2;
        OP_BR:   pc_d = cond_taken ? br_target : pc2;
        OP_HLT: begin
          pc_d    = pc_q;
          state_d = ST_HALT;
        end
        default: pc_d = pc2;
      endcase

      branch_taken_d = br_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      pc_q           <= RESET_PC;
      flags_q        <= 3'b000;
      branch_taken_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      flags_q        <= flags_d;
      branch_taken_q <= branch_taken_d;
    end
  end

  assign pc           = pc_q;
  assign flags        = flags_q;
  assign branch_taken = branch_taken_q;
  assign halted       = (state_q == ST_HALT);

`ifdef PC_FLAG_CTRL_PERF_CNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;

  // Saturating; br_taken already excludes HALT through retire.
  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (br_taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt_q <= 16'h0000;
    end else begin
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign taken_cnt = taken_cnt_q;
`endif

endmodule

// File: tb/tb_pc_flag_ctrl.sv
// Directed-vector bench for pc_flag_ctrl with hand-computed expectations.
module tb_pc_flag_ctrl;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        stall;
  logic [3:0]  opcode;
  logic [2:0]  cond;
  logic [8:0]  imm9;
  logic [15:0] br_target;
  logic [2:0]  alu_flag;
  logic [15:0] pc;
  logic [2:0]  flags;
  logic        branch_taken;
  logic        halted;
`ifdef PC_FLAG_CTRL_PERF_CNT_EN
  logic [15:0] taken_cnt;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  pc_flag_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .stall        (stall),
    .opcode       (opcode),
    .cond         (cond),
    .imm9         (imm9),
    .br_target    (br_target),
    .alu_flag     (alu_flag),
    .pc           (pc),
    .flags        (flags),
    .branch_taken (branch_taken),
`ifdef PC_FLAG_CTRL_PERF_CNT_EN
    .taken_cnt    (taken_cnt),
`endif
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [2:0] cc, input logic [8:0] imm,
                       input logic [15:0] tgt, input logic [2:0] af, input logic stl);
    instr_valid = 1'b1;
    stall       = stl;
    opcode      = op;
    cond        = cc;
    imm9        = imm;
    br_target   = tgt;
    alu_flag    = af;
    step();
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    stall       = 1'b0;
    step();
  endtask

  task automatic chk_state(input string tag, input logic [15:0] epc, input logic [2:0] efl,
                           input logic ebt, input logic eh);
    chk_eq({tag, ".pc"},     pc,                    epc);
    chk_eq({tag, ".flags"},  {13'd0, flags},        {13'd0, efl});
    chk_eq({tag, ".bt"},     {15'd0, branch_taken}, {15'd0, ebt});
    chk_eq({tag, ".halted"}, {15'd0, halted},       {15'd0, eh});
  endtask

  localparam logic [3:0] ADD = 4'd0, SUB = 4'd1, XOR = 4'd2, B = 4'd12, BR = 4'd13, HLT = 4'd15;

  initial begin
    logic [2:0]  cc_list [4];
    logic        bt_list [4];

    rst_n = 1'b0; instr_valid = 1'b0; stall = 1'b0; opcode = 4'd0; cond = 3'd0;
    imm9 = 9'd0; br_target = 16'd0; alu_flag = 3'd0;
    repeat (2) step();
    chk_state("reset", 16'h0000, 3'b000, 1'b0, 1'b0);
`ifdef PC_FLAG_CTRL_PERF_CNT_EN
    chk_eq("reset.cnt", taken_cnt, 16'h0000);
`endif
    @(negedge clk); rst_n = 1'b1;
    step();

    // Three ADDs: pc 0 -> 2 -> 4 -> 6, flags follow alu_flag
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b100, 1'b0); chk_state("add1", 16'h0002, 3'b100, 1'b0, 1'b0);
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b010, 1'b0); chk_state("add2", 16'h0004, 3'b010, 1'b0, 1'b0);
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b001, 1'b0); chk_state("add3", 16'h0006, 3'b001, 1'b0, 1'b0);

    // Walk to pc=0x0E, then SUB sets Z and lands at 0x10
    repeat (4) issue(ADD, 3'd0, 9'd0, 16'd0, 3'b000, 1'b0);
    issue(SUB, 3'd0, 9'd0, 16'd0, 3'b001, 1'b0); chk_state("sub", 16'h0010, 3'b001, 1'b0, 1'b0);

    // B EQ -2 words from 0x10: 0x12 - 4 = 0x0E
    issue(B, 3'b001, 9'h1FE, 16'd0, 3'b111, 1'b0); chk_state("b_eq", 16'h000E, 3'b001, 1'b1, 1'b0);
    idle(); chk_state("b_eq_after", 16'h000E, 3'b001, 1'b0, 1'b0);

    // XOR writes Z only
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b000, 1'b0); chk_state("add_clr", 16'h0010, 3'b000, 1'b0, 1'b0);
    issue(XOR, 3'd0, 9'd0, 16'd0, 3'b110, 1'b0); chk_state("xor1", 16'h0012, 3'b000, 1'b0, 1'b0);
    issue(B, 3'b110, 9'h004, 16'd0, 3'b000, 1'b0); chk_state("b_ovfl_nt", 16'h0014, 3'b000, 1'b0, 1'b0);
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b110, 1'b0); chk_state("add_nv", 16'h0016, 3'b110, 1'b0, 1'b0);
    issue(XOR, 3'd0, 9'd0, 16'd0, 3'b001, 1'b0); chk_state("xor2", 16'h0018, 3'b111, 1'b0, 1'b0);
    // V=1: taken, 0x1A + 8 = 0x22
    issue(B, 3'b110, 9'h004, 16'd0, 3'b000, 1'b0); chk_state("b_ovfl_t", 16'h0022, 3'b111, 1'b1, 1'b0);

    // BR UNC held by stall for 3 cycles
    for (int i = 0; i < 3; i++) begin
      issue(BR, 3'b111, 9'd0, 16'h1234, 3'b000, 1'b1);
      chk_state("br_stall", 16'h0022, 3'b111, 1'b0, 1'b0);
    end
    issue(BR, 3'b111, 9'd0, 16'h1234, 3'b000, 1'b0); chk_state("br_go", 16'h1234, 3'b111, 1'b1, 1'b0);
    idle(); chk_state("br_after", 16'h1234, 3'b111, 1'b0, 1'b0);

    // BR NE with Z=1: not taken
    issue(BR, 3'b000, 9'd0, 16'h4444, 3'b000, 1'b0); chk_state("br_ne_nt", 16'h1236, 3'b111, 1'b0, 1'b0);

    // Wrap at 0xFFFE
    issue(BR, 3'b111, 9'd0, 16'hFFFE, 3'b000, 1'b0); chk_state("br_fffe", 16'hFFFE, 3'b111, 1'b1, 1'b0);
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b010, 1'b0); chk_state("wrap", 16'h0000, 3'b010, 1'b0, 1'b0);

    // Flags V only: GT taken, LT not, GE taken, LE not
    cc_list = '{3'b010, 3'b011, 3'b100, 3'b101};
    bt_list = '{1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      issue(B, cc_list[i], 9'h000, 16'd0, 3'b000, 1'b0);
      chk_state("b_cc", 16'(2 * (i + 1)), 3'b010, bt_list[i], 1'b0);
    end

`ifdef PC_FLAG_CTRL_PERF_CNT_EN
    chk_eq("cnt", taken_cnt, 16'd6);
`endif

    // HLT holds pc and freezes everything after
    issue(HLT, 3'd0, 9'd0, 16'd0, 3'b111, 1'b0); chk_state("hlt", 16'h0008, 3'b010, 1'b0, 1'b1);
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b111, 1'b0); chk_state("halt_add", 16'h0008, 3'b010, 1'b0, 1'b1);
    issue(BR, 3'b111, 9'd0, 16'h5555, 3'b101, 1'b0); chk_state("halt_br", 16'h0008, 3'b010, 1'b0, 1'b1);
`ifdef PC_FLAG_CTRL_PERF_CNT_EN
    chk_eq("cnt_halt", taken_cnt, 16'd6);
`endif

    // Asynchronous reset mid-cycle
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 16'h0000, 3'b000, 1'b0, 1'b0);
`ifdef PC_FLAG_CTRL_PERF_CNT_EN
    chk_eq("async_rst.cnt", taken_cnt, 16'h0000);
`endif
    @(negedge clk); rst_n = 1'b1;
    issue(ADD, 3'd0, 9'd0, 16'd0, 3'b101, 1'b0); chk_state("post_rst", 16'h0002, 3'b101, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
